// File: rtl/egress_pkg.sv
// Shared constants and types for the egress word pacer and its FIFO.
package egress_pkg;

    localparam int EGRESS_WORD_W         = 32;
    localparam int EGRESS_BYTES_PER_WORD = 4;
    // The serializer shifts one byte per clock, so a word occupies it this long.
    localparam int EGRESS_GAP_DEFAULT    = EGRESS_BYTES_PER_WORD;

    typedef enum logic [0:0] {
        EGRESS_IDLE    = 1'b0,
        EGRESS_HOLDOFF = 1'b1
    } egress_state_e;

endpackage

// File: rtl/egress_sync_fifo.sv
// Single-clock circular word FIFO with a separate occupancy counter and a
// sticky overflow flag for producer pushes that are refused while full.
module egress_sync_fifo
    import egress_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          push_req_i,
    input  logic [EGRESS_WORD_W-1:0]      push_data_i,
    input  logic                          pop_i,
    output logic [EGRESS_WORD_W-1:0]      pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0]    level_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [EGRESS_WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic                     overflow_q, overflow_d;
    logic                     full_s;
    logic                     empty_s;
    logic                     push_s;

    assign full_s  = (level_q == LVL_W'(DEPTH));
    assign empty_s = (level_q == {LVL_W{1'b0}});
    assign push_s  = push_req_i && !full_s;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (push_req_i & full_s);
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care after reset since level gates reads.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;
    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/egress_word_pacer.sv
// Buffers producer words and issues them to the byte serializer as single-cycle
// strobes spaced at least GAP clocks apart, only while the serializer is ready.
module egress_word_pacer
    import egress_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = EGRESS_GAP_DEFAULT
) (
    input  logic                          ClkEngress,
    input  logic                          ARst,
    input  logic [EGRESS_WORD_W-1:0]      InData,
    input  logic                          InValid,
    output logic                          InReady,
    output logic [EGRESS_WORD_W-1:0]      OutData,
    output logic                          OutValid,
    input  logic                          EgressReady,
    output logic [$clog2(DEPTH+1)-1:0]    Level,
    output logic                          Overflow
);

    localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;

    egress_state_e            state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [EGRESS_WORD_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     pop_s;
    logic                     full_s;
    logic                     empty_s;
    logic [EGRESS_WORD_W-1:0] fifo_data_s;

    egress_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (ClkEngress),
        .arst_i      (ARst),
        .push_req_i  (InValid),
        .push_data_i (InData),
        .pop_i       (pop_s),
        .pop_data_o  (fifo_data_s),
        .level_o     (Level),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .overflow_o  (Overflow)
    );

    assign InReady = !full_s;

    // Issue decision, holdoff countdown and output register next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        pop_s       = 1'b0;
        case (state_q)
            EGRESS_IDLE: begin
                if (!empty_s && EgressReady) begin
                    pop_s       = 1'b1;
                    out_data_d  = fifo_data_s;
                    out_valid_d = 1'b1;
                    cnt_d       = CNT_W'(GAP - 1);
                    state_d     = EGRESS_HOLDOFF;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            EGRESS_HOLDOFF: begin
                // Leaving on the 1->0 step lets IDLE issue exactly GAP edges later.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = EGRESS_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = EGRESS_HOLDOFF;
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = EGRESS_IDLE;
            end
        endcase
    end

    // FSM, holdoff counter and serializer-facing output registers.
    always_ff @(posedge ClkEngress or posedge ARst) begin
        if (ARst) begin
            state_q     <= EGRESS_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            out_data_q  <= {EGRESS_WORD_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OutData  = out_data_q;
    assign OutValid = out_valid_q;

endmodule

// File: tb/tb_egress_word_pacer.sv
// Directed self-checking bench for egress_word_pacer (DEPTH=8, GAP=4).
module tb_egress_word_pacer;

    logic        clk;
    logic        arst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        egress_ready;
    logic [3:0]  level;
    logic        overflow;

    int n_cmp;
    int n_bad;

    egress_word_pacer #(.DEPTH(8), .GAP(4)) dut (
        .ClkEngress  (clk),
        .ARst        (arst),
        .InData      (in_data),
        .InValid     (in_valid),
        .InReady     (in_ready),
        .OutData     (out_data),
        .OutValid    (out_valid),
        .EgressReady (egress_ready),
        .Level       (level),
        .Overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst         = 1'b1;
        in_valid     = 1'b0;
        in_data      = 32'h0;
        egress_ready = 1'b0;
        repeat (2) tick();
        arst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_outvalid got %0b exp 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_outdata got %h exp 0", out_data); end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level got %0d exp 0", level); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_inready got %0b exp 1", in_ready); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    endtask

    task automatic test_single();
        do_reset();
        egress_ready = 1'b1;
        in_valid     = 1'b1;
        in_data      = 32'hA1B2C3D4;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early got %0b exp 0", out_valid); end
        n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level1 got %0d exp 1", level); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_pulse got %0b exp 1", out_valid); end
        n_cmp++; if (out_data !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL single_data got %h exp a1b2c3d4", out_data); end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL single_level0 got %0d exp 0", level); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_width got %0b exp 0", out_valid); end
        n_cmp++; if (out_data !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL single_hold got %h exp a1b2c3d4", out_data); end
    endtask

    task automatic test_burst();
        int npulse;
        npulse = 0;
        do_reset();
        egress_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < 8) begin
                in_valid = 1'b1;
                in_data  = 32'(cyc + 1);
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL burst_inready cyc %0d got %0b exp 1", cyc, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid === 1'b1) begin
                n_cmp++; if (cyc != 1 + 4 * npulse) begin n_bad++; $display("FAIL burst_spacing pulse %0d got cyc %0d exp %0d", npulse, cyc, 1 + 4 * npulse); end
                n_cmp++; if (out_data !== 32'(npulse + 1)) begin n_bad++; $display("FAIL burst_order got %h exp %h", out_data, 32'(npulse + 1)); end
                npulse++;
            end
        end
        n_cmp++; if (npulse != 8) begin n_bad++; $display("FAIL burst_count got %0d exp 8", npulse); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL burst_overflow got %0b exp 0", overflow); end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL burst_level got %0d exp 0", level); end
    endtask

    task automatic test_overflow();
        int npulse;
        npulse = 0;
        do_reset();
        egress_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i + 1);
            tick();
        end
        n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf_level got %0d exp 8", level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_inready got %0b exp 0", in_ready); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early got %0b exp 0", overflow); end
        in_data = 32'd9;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
        n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf_level9 got %0d exp 8", level); end
        egress_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (out_valid === 1'b1) begin
                n_cmp++; if (out_data !== 32'(npulse + 1)) begin n_bad++; $display("FAIL ovf_drain got %h exp %h", out_data, 32'(npulse + 1)); end
                npulse++;
            end
        end
        n_cmp++; if (npulse != 8) begin n_bad++; $display("FAIL ovf_count got %0d exp 8", npulse); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_hold got %0b exp 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        int npulse;
        npulse = 0;
        do_reset();
        egress_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h40 + 32'(i);
            tick();
        end
        in_data      = 32'h55;
        egress_ready = 1'b1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fpp_pre_inready got %0b exp 0", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (level !== 4'd7) begin n_bad++; $display("FAIL fpp_level got %0d exp 7", level); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fpp_inready got %0b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fpp_issue got %0b exp 1", out_valid); end
        n_cmp++; if (out_data !== 32'h40) begin n_bad++; $display("FAIL fpp_data got %h exp 00000040", out_data); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fpp_overflow got %0b exp 1", overflow); end
        for (int cyc = 0; cyc < 36; cyc++) begin
            tick();
            if (out_valid === 1'b1) begin
                n_cmp++; if (out_data !== 32'h41 + 32'(npulse)) begin n_bad++; $display("FAIL fpp_drain got %h exp %h", out_data, 32'h41 + 32'(npulse)); end
                npulse++;
            end
        end
        n_cmp++; if (npulse != 7) begin n_bad++; $display("FAIL fpp_count got %0d exp 7", npulse); end
    endtask

    task automatic test_ready_low_holdoff();
        do_reset();
        egress_ready = 1'b0;
        in_valid     = 1'b1;
        in_data      = 32'hAAAA0001;
        tick();
        in_data = 32'hBBBB0002;
        tick();
        in_valid     = 1'b0;
        egress_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA0001) begin n_bad++; $display("FAIL hold_first got v=%0b d=%h exp v=1 d=aaaa0001", out_valid, out_data); end
        tick();
        egress_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_early step %0d got %0b exp 0", i, out_valid); end
        end
        egress_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_resume got %0b exp 1", out_valid); end
        n_cmp++; if (out_data !== 32'hBBBB0002) begin n_bad++; $display("FAIL hold_data got %h exp bbbb0002", out_data); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        egress_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h60 + 32'(i);
            tick();
        end
        in_valid     = 1'b0;
        egress_ready = 1'b1;
        tick();
        n_cmp++; if (level !== 4'd5 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got lvl=%0d v=%0b exp lvl=5 v=1", level, out_valid); end
        arst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_outvalid got %0b exp 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL mid_outdata got %h exp 0", out_data); end
        n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL mid_level got %0d exp 0", level); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_inready got %0b exp 1", in_ready); end
        tick();
        arst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0 || level !== 4'd0) begin n_bad++; $display("FAIL mid_stale step %0d got v=%0b lvl=%0d exp v=0 lvl=0", i, out_valid, level); end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        arst         = 1'b1;
        in_valid     = 1'b0;
        in_data      = 32'h0;
        egress_ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_push_pop();
        test_ready_low_holdoff();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
